// File: rtl/trig_frame_sched_if.sv
// ---------------------------------------------------------------------------
// trig_frame_sched_if
// Bundles the request/grant and frame signals between the trigger frame
// scheduler and its surroundings (serializer, requesters, control).
//
//   frame_load    serializer frame-boundary strobe (1 cycle in every 4)
//   l1a_in        one-cycle trigger pulse
//   ecr_req/ack   event-counter-reset request (level) / grant (pulse)
//   cal_req/ack   calibration request (level) / grant (pulse)
//   bcr_en        enables the automatic BCR orbit generator
//   ovf_clr       clears the sticky L1A overflow flag
//   frame_data    nibble presented to the serializer parallel input
//   l1a_pending   number of queued L1As
//   l1a_overflow  sticky flag: an L1A was dropped
//
// master: the environment side. slave: the scheduler.
// ---------------------------------------------------------------------------
interface trig_frame_sched_if;
  logic       frame_load;
  logic       l1a_in;
  logic       ecr_req;
  logic       ecr_ack;
  logic       cal_req;
  logic       cal_ack;
  logic       bcr_en;
  logic       ovf_clr;
  logic [3:0] frame_data;
  logic [2:0] l1a_pending;
  logic       l1a_overflow;

  modport master (
    output frame_load, l1a_in, ecr_req, cal_req, bcr_en, ovf_clr,
    input  ecr_ack, cal_ack, frame_data, l1a_pending, l1a_overflow
  );

  modport slave (
    input  frame_load, l1a_in, ecr_req, cal_req, bcr_en, ovf_clr,
    output ecr_ack, cal_ack, frame_data, l1a_pending, l1a_overflow
  );
endinterface

// File: rtl/trig_frame_sched.sv
// ---------------------------------------------------------------------------
// trig_frame_sched
// Chooses one 4-bit command frame per serializer frame period. On each
// commit edge (rising clk40 with frame_load=1) the highest-priority pending
// item is loaded into frame_data and held for the whole frame:
//   L1A (queued count > 0) > BCR (orbit wrap pending) > ECR > CAL > idle.
// L1As are queued in a 3-bit saturating counter; a trigger arriving while
// the queue is full and not draining is dropped and flagged.
// An orbit counter raises a single BCR request every BCR_PERIOD cycles.
//
// Ports
//   clk40  40 MHz clock, all state on the rising edge
//   rst    asynchronous, active-high reset
//   bus    trig_frame_sched_if.slave (see interface header)
// ---------------------------------------------------------------------------
module trig_frame_sched #(
  parameter int         BCR_PERIOD = 3564,
  parameter logic [3:0] CODE_L1A   = 4'h9,
  parameter logic [3:0] CODE_BCR   = 4'h5,
  parameter logic [3:0] CODE_ECR   = 4'h3,
  parameter logic [3:0] CODE_CAL   = 4'h6
) (
  input  logic                 clk40,
  input  logic                 rst,
  trig_frame_sched_if.slave    bus
);

  localparam logic [3:0]  CODE_IDLE  = 4'h0;
  localparam logic [11:0] ORBIT_LAST = 12'(BCR_PERIOD - 1);
  localparam logic [2:0]  L1A_FULL   = 3'd7;

  logic [2:0]  r_l1a_cnt;
  logic        r_l1a_ovf;
  logic [11:0] r_orbit;
  logic        r_bcr_pend;
  logic [3:0]  r_frame_p1;
  logic        r_ecr_ack_p1;
  logic        r_cal_ack_p1;

  logic        w_commit;
  logic [3:0]  w_sel_code;
  logic        w_sel_l1a;
  logic        w_sel_bcr;
  logic        w_sel_ecr;
  logic        w_sel_cal;
  logic        w_inc;
  logic        w_dec;
  logic        w_drop;
  logic        w_wrap;

  assign w_commit = bus.frame_load;

  // Priority selection from state registered before the edge; a trigger
  // arriving on the commit edge itself is not yet visible here.
  always_comb begin
    w_sel_code = CODE_IDLE;
    w_sel_l1a  = 1'b0;
    w_sel_bcr  = 1'b0;
    w_sel_ecr  = 1'b0;
    w_sel_cal  = 1'b0;
    if (r_l1a_cnt != 3'd0) begin
      w_sel_code = CODE_L1A;
      w_sel_l1a  = 1'b1;
    end else if (r_bcr_pend) begin
      w_sel_code = CODE_BCR;
      w_sel_bcr  = 1'b1;
    end else if (bus.ecr_req) begin
      w_sel_code = CODE_ECR;
      w_sel_ecr  = 1'b1;
    end else if (bus.cal_req) begin
      w_sel_code = CODE_CAL;
      w_sel_cal  = 1'b1;
    end
  end

  assign w_inc  = bus.l1a_in;
  assign w_dec  = w_commit & w_sel_l1a;
  // A full queue that drains on the same edge still accepts the trigger.
  assign w_drop = w_inc & ~w_dec & (r_l1a_cnt == L1A_FULL);
  assign w_wrap = bus.bcr_en & (r_orbit == ORBIT_LAST);

  // L1A queue and sticky overflow
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_l1a_cnt <= 3'd0;
    end else if (w_inc & ~w_dec & (r_l1a_cnt != L1A_FULL)) begin
      r_l1a_cnt <= r_l1a_cnt + 3'd1;
    end else if (w_dec & ~w_inc) begin
      r_l1a_cnt <= r_l1a_cnt - 3'd1;
    end
  end

  // Set has priority over clear so a drop is never lost.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_l1a_ovf <= 1'b0;
    end else if (w_drop) begin
      r_l1a_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_l1a_ovf <= 1'b0;
    end
  end

  // Orbit generator; a wrap while BCR is already pending is absorbed.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_orbit <= 12'd0;
    end else if (!bus.bcr_en || w_wrap) begin
      r_orbit <= 12'd0;
    end else begin
      r_orbit <= r_orbit + 12'd1;
    end
  end

  // Wrap beats the serving commit on the same edge, leaving one BCR pending.
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_bcr_pend <= 1'b0;
    end else if (!bus.bcr_en) begin
      r_bcr_pend <= 1'b0;
    end else if (w_wrap) begin
      r_bcr_pend <= 1'b1;
    end else if (w_commit & w_sel_bcr) begin
      r_bcr_pend <= 1'b0;
    end
  end

  // ---- stage p1: committed frame and grant pulses ----
  always_ff @(posedge clk40 or posedge rst) begin
    if (rst) begin
      r_frame_p1   <= CODE_IDLE;
      r_ecr_ack_p1 <= 1'b0;
      r_cal_ack_p1 <= 1'b0;
    end else begin
      if (w_commit) begin
        r_frame_p1 <= w_sel_code;
      end
      r_ecr_ack_p1 <= w_commit & w_sel_ecr;
      r_cal_ack_p1 <= w_commit & w_sel_cal;
    end
  end

  assign bus.frame_data   = r_frame_p1;
  assign bus.ecr_ack      = r_ecr_ack_p1;
  assign bus.cal_ack      = r_cal_ack_p1;
  assign bus.l1a_pending  = r_l1a_cnt;
  assign bus.l1a_overflow = r_l1a_ovf;

endmodule

// File: tb/tb_trig_frame_sched.sv
`timescale 1ns/1ps
module tb_trig_frame_sched;

  logic clk40;
  logic rst;
  int   n_tot = 0;
  int   n_bad = 0;
  int   ph    = 0;
  bit   fl_en = 1'b1;

  trig_frame_sched_if bus ();

  trig_frame_sched #(
    .BCR_PERIOD (16),
    .CODE_L1A   (4'h9),
    .CODE_BCR   (4'h5),
    .CODE_ECR   (4'h3),
    .CODE_CAL   (4'h6)
  ) dut (
    .clk40 (clk40),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial begin
    clk40 = 1'b0;
    forever #12.5 clk40 = ~clk40;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One clock; pulses end, requesters drop req after seeing ack,
  // and frame_load follows a 1-in-4 schedule (gated by fl_en).
  task automatic step();
    @(posedge clk40);
    #1;
    bus.l1a_in  = 1'b0;
    bus.ovf_clr = 1'b0;
    if (bus.ecr_ack) bus.ecr_req = 1'b0;
    if (bus.cal_ack) bus.cal_req = 1'b0;
    ph++;
    bus.frame_load = fl_en && (ph % 4 == 3);
  endtask

  // Advance until frame_load is high (next edge is a commit).
  task automatic to_load();
    int seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.frame_load) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("load_seen", seen, 1);
  endtask

  // Advance through the next commit edge; returns #1 after it.
  task automatic to_commit();
    to_load();
    step();
  endtask

  initial begin
    rst            = 1'b1;
    bus.frame_load = 1'b0;
    bus.l1a_in     = 1'b0;
    bus.ecr_req    = 1'b0;
    bus.cal_req    = 1'b0;
    bus.bcr_en     = 1'b0;
    bus.ovf_clr    = 1'b0;
    #1;
    chk("rst_frame", bus.frame_data, 0);
    chk("rst_pend", bus.l1a_pending, 0);
    chk("rst_ovf", bus.l1a_overflow, 0);
    chk("rst_eack", bus.ecr_ack, 0);
    chk("rst_cack", bus.cal_ack, 0);
    step();
    step();
    rst = 1'b0;
    to_commit();
    chk("idle_frame", bus.frame_data, 0);

    // Three consecutive triggers
    bus.l1a_in = 1'b1; step();
    bus.l1a_in = 1'b1; step();
    bus.l1a_in = 1'b1; step();
    chk("l1a3_pend", bus.l1a_pending, 3);
    to_commit();
    chk("l1a_f1", bus.frame_data, 9);
    chk("l1a_p1", bus.l1a_pending, 2);
    step();
    chk("l1a_hold", bus.frame_data, 9);
    to_commit();
    chk("l1a_f2", bus.frame_data, 9);
    chk("l1a_p2", bus.l1a_pending, 1);
    to_commit();
    chk("l1a_f3", bus.frame_data, 9);
    chk("l1a_p3", bus.l1a_pending, 0);
    to_commit();
    chk("l1a_f4", bus.frame_data, 0);

    // ECR and CAL raised together
    bus.ecr_req = 1'b1;
    bus.cal_req = 1'b1;
    to_commit();
    chk("ecr_frame", bus.frame_data, 3);
    chk("ecr_ack", bus.ecr_ack, 1);
    chk("ecr_cack", bus.cal_ack, 0);
    step();
    chk("ecr_ack_1cyc", bus.ecr_ack, 0);
    to_commit();
    chk("cal_frame", bus.frame_data, 6);
    chk("cal_ack", bus.cal_ack, 1);
    chk("cal_eack", bus.ecr_ack, 0);
    to_commit();
    chk("ec_idle", bus.frame_data, 0);
    chk("ec_idle_cack", bus.cal_ack, 0);

    // Queue overflow without commits
    fl_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.l1a_in = 1'b1;
      step();
    end
    chk("ovf_pend", bus.l1a_pending, 7);
    chk("ovf_set", bus.l1a_overflow, 1);
    bus.ovf_clr = 1'b1; step();
    chk("ovf_clr", bus.l1a_overflow, 0);
    chk("ovf_clr_pend", bus.l1a_pending, 7);
    bus.l1a_in = 1'b1; bus.ovf_clr = 1'b1; step();
    chk("ovf_set_wins", bus.l1a_overflow, 1);
    chk("ovf_sw_pend", bus.l1a_pending, 7);
    bus.ovf_clr = 1'b1; step();
    chk("ovf_clr2", bus.l1a_overflow, 0);
    // Full queue with a trigger on an L1A commit: no drop
    fl_en = 1'b1;
    to_load();
    bus.l1a_in = 1'b1;
    step();
    chk("full_commit_frame", bus.frame_data, 9);
    chk("full_commit_pend", bus.l1a_pending, 7);
    chk("full_commit_ovf", bus.l1a_overflow, 0);
    for (int i = 0; i < 7; i++) to_commit();
    chk("drain_pend", bus.l1a_pending, 0);
    chk("drain_frame", bus.frame_data, 9);
    to_commit();
    chk("drain_idle", bus.frame_data, 0);

    // Trigger on the commit edge with an empty queue
    to_load();
    bus.cal_req = 1'b1;
    bus.l1a_in  = 1'b1;
    step();
    chk("late_l1a_frame", bus.frame_data, 6);
    chk("late_l1a_cack", bus.cal_ack, 1);
    chk("late_l1a_pend", bus.l1a_pending, 1);
    to_commit();
    chk("late_l1a_next", bus.frame_data, 9);
    chk("late_l1a_p0", bus.l1a_pending, 0);
    to_commit();
    chk("late_l1a_idle", bus.frame_data, 0);

    // Orbit BCR with period 16; wraps on edges 16, 32, 48 after enable
    bus.bcr_en = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("bcr_e16", bus.frame_data, 0);
    to_commit();
    chk("bcr_e20", bus.frame_data, 5);
    for (int i = 0; i < 3; i++) begin
      to_commit();
      chk("bcr_gap", bus.frame_data, 0);
    end
    to_commit();
    chk("bcr_e36", bus.frame_data, 5);
    for (int i = 0; i < 3; i++) begin
      to_commit();
      chk("bcr_gap2", bus.frame_data, 0);
    end
    bus.l1a_in = 1'b1;
    step();
    to_commit();
    chk("bcr_l1a_first", bus.frame_data, 9);
    to_commit();
    chk("bcr_delayed", bus.frame_data, 5);
    bus.bcr_en = 1'b0;
    to_commit();
    chk("bcr_off", bus.frame_data, 0);

    // Reset mid-operation
    fl_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.l1a_in = 1'b1;
      step();
    end
    fl_en = 1'b1;
    to_commit();
    chk("pre_rst_frame", bus.frame_data, 9);
    chk("pre_rst_pend", bus.l1a_pending, 5);
    rst = 1'b1;
    #2;
    chk("arst_frame", bus.frame_data, 0);
    chk("arst_pend", bus.l1a_pending, 0);
    chk("arst_ovf", bus.l1a_overflow, 0);
    chk("arst_eack", bus.ecr_ack, 0);
    chk("arst_cack", bus.cal_ack, 0);
    bus.cal_req = 1'b1;
    step();
    step();
    rst = 1'b0;
    to_commit();
    chk("post_rst_frame", bus.frame_data, 6);
    chk("post_rst_cack", bus.cal_ack, 1);
    chk("post_rst_pend", bus.l1a_pending, 0);
    to_commit();
    chk("post_rst_idle", bus.frame_data, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/trig_frame_sched.md
TRIG_FRAME_SCHED -- requirements
Module: trig_frame_sched

Interface
REQ-001 Parameter BCR_PERIOD, default 3564: clk40 cycles between automatic BCR requests (legal range 8..4095).
REQ-002 Parameter CODE_L1A, default 4'h9: frame code for one L1A.
REQ-003 Parameter CODE_BCR, default 4'h5: frame code for bunch-counter reset.
REQ-004 Parameter CODE_ECR, default 4'h3: frame code for event-counter reset.
REQ-005 Parameter CODE_CAL, default 4'h6: frame code for calibration pulse.
REQ-006 Idle code SHALL be 4'h0; all parameter codes SHALL be nonzero and distinct.
REQ-007 clk40  in  1  40 MHz clock; all state on its rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 frame_load  in  1  serializer frame-boundary strobe, high 1 cycle in every 4.
REQ-010 l1a_in  in  1  one-cycle trigger pulse; any cycle.
REQ-011 ecr_req  in  1  ECR request, level, held until ecr_ack.
REQ-012 ecr_ack  out  1  one-cycle grant pulse for ECR.
REQ-013 cal_req  in  1  CAL request, level, held until cal_ack.
REQ-014 cal_ack  out  1  one-cycle grant pulse for CAL.
REQ-015 bcr_en  in  1  enables the automatic BCR orbit generator.
REQ-016 ovf_clr  in  1  clears l1a_overflow.
REQ-017 frame_data  out  4  nibble driven to the serializer's parallel input.
REQ-018 l1a_pending  out  3  queued L1A count.
REQ-019 l1a_overflow  out  1  sticky flag: an L1A was dropped.

Function
REQ-020 Commit edge: rising clk40 edge where frame_load=1; frame_data SHALL change only on commit edges and on reset.
REQ-021 At commit, frame_data SHALL be loaded with the highest-priority pending item, using values registered before the edge: L1A (l1a_pending>0) > BCR (bcr_pending=1) > ECR (ecr_req=1) > CAL (cal_req=1) > idle 4'h0.
REQ-022 Selected frame SHALL be held on frame_data for the 4 cycles up to and including the next frame_load cycle, when the serializer captures it.
REQ-023 ecr_ack / cal_ack SHALL be registered high for exactly the cycle after the commit edge that selected ECR / CAL; never both, never without a commit.
REQ-024 Requesters drop req on the edge after ack; a req still high at the next commit SHALL be served again.
REQ-025 l1a_pending: +1 on edge with l1a_in=1; -1 on commit selecting L1A; both on same edge -> unchanged.
REQ-026 l1a_in=1 with l1a_pending=7 and no decrement on that edge: trigger dropped, count stays 7, l1a_overflow set.
REQ-027 l1a_pending=7 with l1a_in=1 and an L1A commit on the same edge: count stays 7, no overflow.
REQ-028 l1a_in on a commit edge with l1a_pending=0: that commit SHALL select a lower-priority item; count becomes 1.
REQ-029 l1a_overflow SHALL clear on edge with ovf_clr=1; if set and clear coincide, set wins.
REQ-030 Orbit counter (12-bit) SHALL count 0..BCR_PERIOD-1 and wrap while bcr_en=1; on the wrap edge bcr_pending SHALL be set.
REQ-031 bcr_pending SHALL clear on commit selecting BCR; a wrap on that same edge leaves it set; a wrap while already set is absorbed (single BCR).
REQ-032 bcr_en=0: orbit counter held at 0, bcr_pending cleared on the next edge.
REQ-033 Continuous L1A at one per 4 cycles starves BCR/ECR/CAL; this SHALL be accepted behaviour.

Reset
REQ-034 rst=1 SHALL immediately force frame_data=4'h0, ecr_ack=0, cal_ack=0, l1a_pending=0, l1a_overflow=0, orbit counter=0, bcr_pending=0.
REQ-035 Reset mid-operation discards queued L1As and pending BCR; reqs still high after release SHALL be served by normal priority.

Verification
REQ-036 Three l1a_in pulses in consecutive cycles, idle reqs -> next three frames 4'h9, l1a_pending 3->2->1->0, fourth frame 4'h0.
REQ-037 ecr_req and cal_req raised together, no L1A -> frame 4'h3 + ecr_ack; next frame 4'h6 + cal_ack; then 4'h0.
REQ-038 Eight l1a_in pulses without commits -> l1a_pending=7, l1a_overflow=1; ovf_clr pulse -> l1a_overflow=0, count unchanged.
REQ-039 BCR_PERIOD=16, bcr_en=1 -> BCR frame 4'h5 once per 16 cycles; L1A pending at the commit delays BCR one frame, not dropped.
REQ-040 rst pulse with l1a_pending=5 and frame_data=4'h9 -> outputs zero at once; after release with cal_req high -> first commit yields 4'h6.
